// File: rtl/izh_scheduler.sv
// izh_scheduler: sweeps N virtual neurons through one shared Izhikevich
// update datapath. Per-neuron v/u/current state lives here; operands go out
// over a valid/ready issue handshake and results return on a dp_done pulse.
module izh_scheduler #(
  parameter int          N       = 4,
  parameter logic [7:0]  V_RESET = 8'd0,
  parameter logic [7:0]  U_RESET = 8'd0,
  parameter logic [7:0]  CHAIN_W = 8'd32,
  localparam int         IW      = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick,
  input  logic          chain_en,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_addr,
  input  logic [7:0]    cfg_data,
  output logic          dp_valid,
  input  logic          dp_ready,
  output logic [7:0]    dp_v,
  output logic [7:0]    dp_u,
  output logic [7:0]    dp_current,
  input  logic          dp_done,
  input  logic [7:0]    dp_v_next,
  input  logic [7:0]    dp_u_next,
  input  logic          dp_spike,
  output logic [N-1:0]  spike_vec,
  output logic          busy,
  output logic          sweep_done,
  output logic          overrun,
  input  logic [IW-1:0] mon_sel,
  output logic [7:0]    mon_v
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic          load_ops;
  logic          wb_en;
  logic          overrun_reg;
  logic          chain_add;
  logic [8:0]    cur_sum;
  logic [7:0]    cur_sat;

  logic [7:0]    v_reg   [N];
  logic [7:0]    u_reg   [N];
  logic [7:0]    cur_reg [N];

  // Per-neuron storage: state written back only for the neuron in WAIT,
  // current register written by the config port at any time.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_neuron
      logic [7:0] v_q, u_q, cur_q;
      logic       spk_q;

      // v/u/spike writeback on completion of this neuron's update
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v_q   <= V_RESET;
          u_q   <= U_RESET;
          spk_q <= 1'b0;
        end else if (wb_en && (idx_reg == IW'(gi))) begin
          v_q   <= dp_v_next;
          u_q   <= dp_u_next;
          spk_q <= dp_spike;
        end
      end

      // input current register, independent of sweep progress
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cur_q <= 8'd0;
        end else if (cfg_we && (cfg_addr == IW'(gi))) begin
          cur_q <= cfg_data;
        end
      end

      assign v_reg[gi]     = v_q;
      assign u_reg[gi]     = u_q;
      assign cur_reg[gi]   = cur_q;
      assign spike_vec[gi] = spk_q;
    end
  endgenerate

  // Next-state logic; load_ops marks every entry into ISSUE
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load_ops   = 1'b0;
    wb_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tick) begin
          state_next = ISSUE;
          idx_next   = '0;
          load_ops   = 1'b1;
        end
      end
      ISSUE: begin
        if (dp_ready) state_next = WAIT;
      end
      WAIT: begin
        if (dp_done) begin
          wb_en = 1'b1;
          if (idx_reg == IW'(N - 1)) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = ISSUE;
            load_ops   = 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Chained current: the previous neuron's spike comes straight off dp_spike
  // on the WAIT->ISSUE edge, since spike_vec has not been updated yet.
  always_comb begin
    chain_add = chain_en && (idx_next != '0) && (state_reg == WAIT) && dp_spike;
    cur_sum   = {1'b0, cur_reg[idx_next]} + (chain_add ? {1'b0, CHAIN_W} : 9'd0);
    cur_sat   = cur_sum[8] ? 8'hFF : cur_sum[7:0];
  end

  // FSM state and sweep index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Operand latch: held stable for the whole ISSUE phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_v       <= V_RESET;
      dp_u       <= U_RESET;
      dp_current <= 8'd0;
    end else if (load_ops) begin
      dp_v       <= v_reg[idx_next];
      dp_u       <= u_reg[idx_next];
      dp_current <= cur_sat;
    end
  end

  // Sticky flag for ticks that arrive while a sweep is still in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_reg <= 1'b0;
    end else if (tick && (state_reg != IDLE)) begin
      overrun_reg <= 1'b1;
    end
  end

  assign dp_valid   = (state_reg == ISSUE);
  assign busy       = (state_reg != IDLE);
  assign sweep_done = (state_reg == DONE);
  assign overrun    = overrun_reg;
  assign mon_v      = v_reg[mon_sel];

endmodule
